// File: rtl/mic1_ula.sv
// MIC-1 ALU: combinational result/flags (zero latency) with registered N/Z (one cycle, sync reset).
// Optional output shifter (SLL8 / SRA1) is compiled in when ULA_SHIFTER_EN is defined.
module mic1_ula #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [5:0]       select,
`ifdef ULA_SHIFTER_EN
   input  logic [1:0]       shift,
   output logic [WIDTH-1:0] sh_out,
`endif
   output logic [WIDTH-1:0] out,
   output logic             N,
   output logic             Z,
   output logic             co,
   output logic             N_q,
   output logic             Z_q
);

   logic [1:0]       func;
   logic             ena, enb, inva, inc;
   logic [WIDTH-1:0] a_op, b_op;
   logic [WIDTH:0]   sum;

   assign func = select[5:4];
   assign ena  = select[3];
   assign enb  = select[2];
   assign inva = select[1];
   assign inc  = select[0];

   assign a_op = (ena ? A : '0) ^ {WIDTH{inva}};
   assign b_op = enb ? B : '0;
   assign sum  = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, inc};

   always_comb begin
      out = '0;
      co  = 1'b0;
      case (func)
         2'b00: out = a_op & b_op;
         2'b01: out = a_op | b_op;
         2'b10: out = ~b_op;
         2'b11: begin
            out = sum[WIDTH-1:0];
            co  = sum[WIDTH];
         end
         default: out = '0;
      endcase
   end

   assign N = out[WIDTH-1];
   assign Z = (out == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         N_q <= 1'b0;
         Z_q <= 1'b0;
      end else begin
         N_q <= N;
         Z_q <= Z;
      end
   end

`ifdef ULA_SHIFTER_EN
   always_comb begin
      sh_out = out;
      case (shift)
         2'b01:   sh_out = out << 8;
         2'b10:   sh_out = {out[WIDTH-1], out[WIDTH-1:1]};
         default: sh_out = out;
      endcase
   end
`endif

endmodule

// File: tb/tb_mic1_ula.sv
// Testbench for mic1_ula: randomized stimulus against an arithmetic reference model plus literal vectors.
module tb_mic1_ula;
   localparam int W = 32;
   localparam longint unsigned MASK = (64'd1 << W) - 1;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] A, B;
   logic [5:0]   sel;
   logic [W-1:0] out;
   logic         N, Z, co, N_q, Z_q;
`ifdef ULA_SHIFTER_EN
   logic [1:0]   shift;
   logic [W-1:0] sh_out;
`endif

   mic1_ula #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .A(A), .B(B), .select(sel),
`ifdef ULA_SHIFTER_EN
      .shift(shift), .sh_out(sh_out),
`endif
      .out(out), .N(N), .Z(Z), .co(co), .N_q(N_q), .Z_q(Z_q)
   );

   always #5 clk = ~clk;

   int   vectors = 0;
   int   miscompares = 0;
   bit   run_chk = 1'b0;
   bit   flags_known = 1'b0;
   logic exp_nq, exp_zq;

   // Returns {carry, result} computed with plain 64-bit arithmetic.
   function automatic logic [W:0] model(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                                        input logic [5:0] s);
      longint unsigned a, b, r;
      a = s[3] ? longint'(a_in) : 0;
      if (s[1]) a = ~a & MASK;
      b = s[2] ? longint'(b_in) : 0;
      case (s[5:4])
         2'd0:    r = a & b;
         2'd1:    r = a | b;
         2'd2:    r = ~b & MASK;
         default: r = a + b + longint'(s[0]);
      endcase
      return r[W:0];
   endfunction

   function automatic logic [W-1:0] shift_model(input logic [W-1:0] v, input logic [1:0] sh);
      longint unsigned x;
      x = longint'(v);
      if (sh == 2'b01) return W'((x * 256) & MASK);
      if (sh == 2'b10) return W'((x / 2) | (v[W-1] ? (64'd1 << (W-1)) : 0));
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (A=%h B=%h select=%b t=%0t)",
                  name, act, exp, A, B, sel, $time);
      end
   endtask

   // Expected registered flags follow the model at every rising edge.
   always @(posedge clk) begin
      logic [W:0] m;
      if (reset === 1'b1) begin
         exp_nq = 1'b0;
         exp_zq = 1'b0;
         flags_known = 1'b1;
      end else if (flags_known) begin
         m = model(A, B, sel);
         exp_nq = m[W-1];
         exp_zq = (m[W-1:0] == '0);
      end
   end

   always @(negedge clk) begin
      logic [W:0] m;
      if (run_chk) begin
         m = model(A, B, sel);
         check("out", 64'(out), 64'(m[W-1:0]));
         check("N",   64'(N),   64'(m[W-1]));
         check("Z",   64'(Z),   64'(m[W-1:0] == '0));
         check("co",  64'(co),  64'(m[W]));
         if (flags_known) begin
            check("N_q", 64'(N_q), 64'(exp_nq));
            check("Z_q", 64'(Z_q), 64'(exp_zq));
         end
`ifdef ULA_SHIFTER_EN
         check("sh_out", 64'(sh_out), 64'(shift_model(m[W-1:0], shift)));
`endif
      end
   end

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [5:0]   s;
      logic [W-1:0] o;
      logic         n;
      logic         z;
      logic         c;
   } lit_t;

   lit_t lits [0:17] = '{
      '{32'h1, 32'h2, 6'b011000, 32'h00000001, 1'b0, 1'b0, 1'b0},
      '{32'h1, 32'h2, 6'b010100, 32'h00000002, 1'b0, 1'b0, 1'b0},
      '{32'h1, 32'h2, 6'b011010, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0},
      '{32'h1, 32'h2, 6'b101100, 32'hFFFFFFFD, 1'b1, 1'b0, 1'b0},
      '{32'h1, 32'h2, 6'b111100, 32'h00000003, 1'b0, 1'b0, 1'b0},
      '{32'h1, 32'h2, 6'b111101, 32'h00000004, 1'b0, 1'b0, 1'b0},
      '{32'h1, 32'h2, 6'b111001, 32'h00000002, 1'b0, 1'b0, 1'b0},
      '{32'h1, 32'h2, 6'b110101, 32'h00000003, 1'b0, 1'b0, 1'b0},
      '{32'h1, 32'h2, 6'b111111, 32'h00000001, 1'b0, 1'b0, 1'b1},
      '{32'h1, 32'h2, 6'b110110, 32'h00000001, 1'b0, 1'b0, 1'b1},
      '{32'h1, 32'h2, 6'b111011, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0},
      '{32'h1, 32'h2, 6'b001100, 32'h00000000, 1'b0, 1'b1, 1'b0},
      '{32'h1, 32'h2, 6'b011100, 32'h00000003, 1'b0, 1'b0, 1'b0},
      '{32'h1, 32'h2, 6'b010000, 32'h00000000, 1'b0, 1'b1, 1'b0},
      '{32'h1, 32'h2, 6'b110001, 32'h00000001, 1'b0, 1'b0, 1'b0},
      '{32'h1, 32'h2, 6'b110010, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0},
      '{32'hFFFFFFFF, 32'h1, 6'b111100, 32'h00000000, 1'b0, 1'b1, 1'b1},
      '{32'hFFFFFFFF, 32'h1, 6'b001100, 32'h00000001, 1'b0, 1'b0, 1'b0}
   };

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return W'($urandom_range(0, 3));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      A = '0;
      B = '0;
      sel = '0;
`ifdef ULA_SHIFTER_EN
      shift = 2'b00;
`endif
      run_chk = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_N_q", 64'(N_q), 64'd0);
      check("reset_Z_q", 64'(Z_q), 64'd0);
      reset = 1'b0;

      foreach (lits[i]) begin
         @(posedge clk);
         #1;
         A = lits[i].a;
         B = lits[i].b;
         sel = lits[i].s;
         @(negedge clk);
         #1;
         check($sformatf("lit%0d_out", i), 64'(out), 64'(lits[i].o));
         check($sformatf("lit%0d_N", i),   64'(N),   64'(lits[i].n));
         check($sformatf("lit%0d_Z", i),   64'(Z),   64'(lits[i].z));
         check($sformatf("lit%0d_co", i),  64'(co),  64'(lits[i].c));
      end

      // Registered zero flag, then a one-edge reset that must clear it without touching out/Z.
      @(posedge clk);
      #1;
      A = 32'h1;
      B = 32'h2;
      sel = 6'b010000;
      @(posedge clk);
      #1;
      check("flag_Z_q_load", 64'(Z_q), 64'd1);
      check("flag_N_q_load", 64'(N_q), 64'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_N_q", 64'(N_q), 64'd0);
      check("rst_Z_q", 64'(Z_q), 64'd0);
      check("rst_out", 64'(out), 64'd0);
      check("rst_Z",   64'(Z),   64'd1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("resume_Z_q", 64'(Z_q), 64'd1);

`ifdef ULA_SHIFTER_EN
      A = 32'h80000001;
      sel = 6'b011000;
      shift = 2'b01;
      #1 check("sh_sll8", 64'(sh_out), 64'h00000100);
      shift = 2'b10;
      #1 check("sh_sra1", 64'(sh_out), 64'hC0000000);
      shift = 2'b11;
      #1 check("sh_pass", 64'(sh_out), 64'h80000001);
`endif

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         A = pick();
         B = pick();
         sel = 6'($urandom_range(0, 63));
         reset = ($urandom_range(0, 19) == 0);
`ifdef ULA_SHIFTER_EN
         shift = 2'($urandom_range(0, 3));
`endif
      end

      @(negedge clk);
      #1;
      run_chk = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mic1_ula.md
MIC1_ULA -- requirements
Module: mic1_ula

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the datapath width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all registers update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port A, input, WIDTH bits, ALU operand A.
REQ-005 The block SHALL have port B, input, WIDTH bits, ALU operand B.
REQ-006 The block SHALL have port select, input, 6 bits: [5]=F0, [4]=F1, [3]=ENA, [2]=ENB, [1]=INVA, [0]=INC.
REQ-007 The block SHALL have port out, output, WIDTH bits, the combinational ALU result.
REQ-008 The block SHALL have port N, output, 1 bit, combinational negative flag.
REQ-009 The block SHALL have port Z, output, 1 bit, combinational zero flag.
REQ-010 The block SHALL have port co, output, 1 bit, combinational carry out of the adder.
REQ-011 The block SHALL have ports N_q and Z_q, output, 1 bit each, the registered N and Z flags.

Function
REQ-012 Operand gating SHALL be: a = ENA ? A : 0, inverted bitwise when INVA=1; b = ENB ? B : 0.
REQ-013 Function selection SHALL be: F0F1=00 -> a AND b; 01 -> a OR b; 10 -> NOT b; 11 -> a + b + INC.
REQ-014 INC SHALL affect only F0F1=11; for the other codes it is ignored.
REQ-015 The sum SHALL be computed modulo 2^WIDTH; co = carry out of bit WIDTH-1 for F0F1=11, else 0.
REQ-016 N SHALL equal out[WIDTH-1]; Z SHALL be 1 exactly when out is all zeros.
REQ-017 out, N, Z and co SHALL be purely combinational from A, B and select, with zero-cycle latency and no dependence on clk or reset.
REQ-018 On each rising clk edge with reset=0, N_q SHALL load N and Z_q SHALL load Z; the registered flags have a one-cycle latency.
REQ-019 All 64 select codes SHALL be legal and decoded per REQ-012..REQ-015; no code produces X.

Reset
REQ-020 When reset=1 at a rising clk edge, N_q and Z_q SHALL be set to 0; reset has priority over the flag load.
REQ-021 Reset SHALL NOT affect out, N, Z or co.
REQ-022 Deasserting reset SHALL resume flag loading on the next rising edge.

Configuration
REQ-023 With macro ULA_SHIFTER_EN defined, the block SHALL add input shift[1:0] and output sh_out[WIDTH-1:0].
REQ-024 sh_out SHALL be: 01 -> out shifted left 8 with zero fill; 10 -> out arithmetic-shifted right 1; 00 and 11 -> out unchanged.
REQ-025 With ULA_SHIFTER_EN undefined, shift and sh_out SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 A=1, B=2, sweep select: 011000->1; 010100->2; 011010->FFFFFFFE with N=1; 101100->FFFFFFFD; 111100->3; 111101->4; 111001->2; 110101->3.
REQ-027 A=1, B=2: 111111->1 (B-A); 110110->1; 111011->FFFFFFFF with N=1; 001100->0 with Z=1; 011100->3; 010000->0 with Z=1; 110001->1; 110010->FFFFFFFF with N=1.
REQ-028 A=FFFFFFFF, B=1, select=111100 -> out=0, Z=1, co=1; select=001100 -> co=0.
REQ-029 Set select=010000, clock once -> Z_q=1 on the following cycle; assert reset for one edge -> N_q=0 and Z_q=0, while out stays 0 and Z stays 1.
REQ-030 With ULA_SHIFTER_EN, out=80000001: shift=01 -> 00000100; shift=10 -> C0000000; shift=11 -> 80000001.
